stack_queue_param: RTL and testbench

Parametrised LIFO/FIFO buffer with a run-time mode select and registered output. It extends the fixed 8×8 push/pop stack to arbitrary width and depth, adds FIFO mode, simultaneous push+pop, an almost-full flag and sticky error flags. It sits between a byte/word producer and consumer in the exercise designs, as a drop-in buffer whose occupancy is visible on `counter`.

---
 rtl/stack_queue_param.sv | 143 ++++++++++++++
 tb/tb_stack_queue_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_queue_param.sv
// stack_queue_param: parametrised LIFO/FIFO buffer with registered output,
// simultaneous push+pop, almost-full decode and sticky error flags.
// The run-time mode is latched only while the buffer is empty.
module stack_queue_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             En,
   input  logic             push,
   input  logic             pop,
   input  logic             mode,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] IN,
   output logic [WIDTH-1:0] OUT,
   output logic [CW-1:0]    counter,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   logic [CW-1:0]    count_reg, count_next;
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [WIDTH-1:0] out_reg, out_next;
   logic             mode_reg;
   logic             ovf_reg, udf_reg;

   logic             is_empty, is_full, eff_fifo;
   logic             wr_en, ovf_evt, udf_evt;
   logic [PW-1:0]    wr_idx, top_idx, free_idx;

   // Circular pointer advance that works for non-power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == CW'(DEPTH));
   // While empty the incoming mode takes effect for this very cycle,
   // so the first push already lands in the right organisation.
   assign eff_fifo = is_empty ? mode : mode_reg;
   assign top_idx  = PW'(count_reg - CW'(1));
   assign free_idx = PW'(count_reg);

   // Decode the requested operation into counter/pointer/output updates.
   always_comb begin
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      out_next    = out_reg;
      wr_en       = 1'b0;
      wr_idx      = free_idx;
      ovf_evt     = 1'b0;
      udf_evt     = 1'b0;
      if (En) begin
         if (push && pop) begin
            if (is_empty) begin
               out_next = IN;
            end else if (eff_fifo) begin
               out_next    = mem[rd_ptr_reg];
               wr_en       = 1'b1;
               wr_idx      = wr_ptr_reg;
               wr_ptr_next = ptr_inc(wr_ptr_reg);
               rd_ptr_next = ptr_inc(rd_ptr_reg);
            end else begin
               out_next = mem[top_idx];
               wr_en    = 1'b1;
               wr_idx   = top_idx;
            end
         end else if (push) begin
            if (is_full) begin
               ovf_evt = 1'b1;
            end else begin
               wr_en      = 1'b1;
               count_next = count_reg + CW'(1);
               if (eff_fifo) begin
                  wr_idx      = wr_ptr_reg;
                  wr_ptr_next = ptr_inc(wr_ptr_reg);
               end
            end
         end else if (pop) begin
            if (is_empty) begin
               udf_evt = 1'b1;
            end else begin
               count_next = count_reg - CW'(1);
               if (eff_fifo) begin
                  out_next    = mem[rd_ptr_reg];
                  rd_ptr_next = ptr_inc(rd_ptr_reg);
               end else begin
                  out_next = mem[top_idx];
               end
            end
         end
      end
   end

   // Control state: occupancy, pointers, output register, mode and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         out_reg    <= '0;
         mode_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         udf_reg    <= 1'b0;
      end else begin
         count_reg  <= count_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         out_reg    <= out_next;
         if (is_empty)
            mode_reg <= mode;
         ovf_reg <= (ovf_reg & ~clr_err) | ovf_evt;
         udf_reg <= (udf_reg & ~clr_err) | udf_evt;
      end
   end

   // Storage array, left unreset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= IN;
   end

   assign OUT         = out_reg;
   assign counter     = count_reg;
   assign empty       = is_empty;
   assign full        = is_full;
   assign almost_full = (count_reg >= CW'(AF_LEVEL));
   assign overflow    = ovf_reg;
   assign underflow   = udf_reg;

endmodule

// File: tb/tb_stack_queue_param.sv
// tb_stack_queue_param: scoreboard bench for stack_queue_param. Two
// instances (8x8 default and 16-bit x 5) share one stimulus bus; a queue
// based reference model predicts every cycle, a monitor checks it.
module tb_stack_queue_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        en = 1'b0, push = 1'b0, pop = 1'b0, mode = 1'b0, clr_err = 1'b0;
   logic        sel = 1'b0;
   logic [15:0] din = '0;

   logic [7:0]  out_a;
   logic [3:0]  cnt_a;
   logic        empty_a, full_a, af_a, ovf_a, udf_a;
   logic [15:0] out_b;
   logic [2:0]  cnt_b;
   logic        empty_b, full_b, af_b, ovf_b, udf_b;

   stack_queue_param dut_a (
      .clk(clk), .reset(reset), .En(en & ~sel), .push(push), .pop(pop),
      .mode(mode), .clr_err(clr_err), .IN(din[7:0]), .OUT(out_a),
      .counter(cnt_a), .empty(empty_a), .full(full_a),
      .almost_full(af_a), .overflow(ovf_a), .underflow(udf_a)
   );

   stack_queue_param #(.WIDTH(16), .DEPTH(5)) dut_b (
      .clk(clk), .reset(reset), .En(en & sel), .push(push), .pop(pop),
      .mode(mode), .clr_err(clr_err), .IN(din), .OUT(out_b),
      .counter(cnt_b), .empty(empty_b), .full(full_b),
      .almost_full(af_b), .overflow(ovf_b), .underflow(udf_b)
   );

   typedef struct {
      bit          sel;
      logic [15:0] out;
      int          cnt;
      int          depth;
      int          af;
      bit          ovf;
      bit          udf;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_txn = 0;

   // reference model: plain queue of stored items
   logic [15:0] mq[$];
   bit          m_mode = 1'b0;
   logic [15:0] m_out = '0;
   bit          m_ovf = 1'b0, m_udf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int cur_depth();
      return sel ? 5 : 8;
   endfunction

   function automatic int cur_af();
      return sel ? 3 : 6;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_mode = 1'b0;
      m_out  = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   task automatic model_step(input bit e, input bit p, input bit q, input bit m,
                             input bit c, input logic [15:0] d);
      bit was_empty;
      bit fifo;
      bit ovf_e, udf_e;
      was_empty = (mq.size() == 0);
      fifo  = was_empty ? m : m_mode;
      ovf_e = 1'b0;
      udf_e = 1'b0;
      if (e) begin
         if (p && q) begin
            if (was_empty) begin
               m_out = d;
            end else begin
               m_out = fifo ? mq.pop_front() : mq.pop_back();
               mq.push_back(d);
            end
         end else if (p) begin
            if (mq.size() == cur_depth()) ovf_e = 1'b1;
            else mq.push_back(d);
         end else if (q) begin
            if (was_empty) udf_e = 1'b1;
            else m_out = fifo ? mq.pop_front() : mq.pop_back();
         end
      end
      if (was_empty) m_mode = m;
      m_ovf = (m_ovf && !c) || ovf_e;
      m_udf = (m_udf && !c) || udf_e;
   endtask

   // one clock of stimulus: drive on the falling edge, predict, enqueue
   task automatic cyc(input bit e, input bit p, input bit q, input bit m,
                      input bit c, input logic [15:0] d);
      exp_t x;
      logic [15:0] dm;
      @(negedge clk);
      dm = sel ? d : {8'h00, d[7:0]};
      en = e; push = p; pop = q; mode = m; clr_err = c; din = dm;
      model_step(e, p, q, m, c, dm);
      x.sel = sel; x.out = m_out; x.cnt = mq.size();
      x.depth = cur_depth(); x.af = cur_af(); x.ovf = m_ovf; x.udf = m_udf;
      exp_q.push_back(x);
   endtask

   task automatic idle_cyc();
      cyc(1'b1, 1'b0, 1'b0, mode, 1'b0, 16'h0);
   endtask

   // asynchronous reset between clock edges, checked before the next edge
   task automatic do_reset();
      logic [15:0] o;
      logic [31:0] cn;
      @(posedge clk);
      #3;
      reset = 1'b0;
      en = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
      #1;
      o  = sel ? out_b : {8'h00, out_a};
      cn = sel ? 32'(cnt_b) : 32'(cnt_a);
      chk("rst_counter", cn, 0);
      chk("rst_out", 32'(o), 0);
      chk("rst_empty", sel ? empty_b : empty_a, 1);
      chk("rst_full", sel ? full_b : full_a, 0);
      chk("rst_almost_full", sel ? af_b : af_a, 0);
      chk("rst_overflow", sel ? ovf_b : ovf_a, 0);
      chk("rst_underflow", sel ? udf_b : udf_a, 0);
      model_clear();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // monitor: after each rising edge compare the DUT with the prediction
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_txn++;
            if (e.sel) begin
               chk("out", 32'(out_b), 32'(e.out));
               chk("counter", 32'(cnt_b), e.cnt);
               chk("empty", empty_b, e.cnt == 0);
               chk("full", full_b, e.cnt == e.depth);
               chk("almost_full", af_b, e.cnt >= e.af);
               chk("overflow", ovf_b, e.ovf);
               chk("underflow", udf_b, e.udf);
            end else begin
               chk("out", 32'(out_a), 32'(e.out));
               chk("counter", 32'(cnt_a), e.cnt);
               chk("empty", empty_a, e.cnt == 0);
               chk("full", full_a, e.cnt == e.depth);
               chk("almost_full", af_a, e.cnt >= e.af);
               chk("overflow", ovf_a, e.ovf);
               chk("underflow", udf_a, e.udf);
            end
            $display("txn %0d inst=%0d exp_cnt=%0d exp_out=%0h exp_ovf=%0b exp_udf=%0b",
                     n_txn, e.sel, e.cnt, e.out, e.ovf, e.udf);
         end
      end
   end

   initial begin
      do_reset();

      // LIFO fill, overflow, drain
      for (int i = 1; i <= 8; i++) cyc(1, 1, 0, 0, 0, 16'(10 * i));
      cyc(1, 1, 0, 0, 0, 16'd90);
      for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0, 16'h0);
      // underflow, clear, clear with simultaneous error
      cyc(1, 0, 1, 0, 0, 16'h0);
      cyc(1, 0, 0, 0, 1, 16'h0);
      cyc(1, 0, 1, 0, 0, 16'h0);
      cyc(1, 0, 1, 0, 1, 16'h0);
      cyc(1, 0, 0, 0, 1, 16'h0);

      // FIFO with pointer wrap
      for (int i = 1; i <= 8; i++) cyc(1, 1, 0, 1, 0, 16'(i));
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0, 16'h0);
      for (int i = 9; i <= 11; i++) cyc(1, 1, 0, 1, 0, 16'(i));
      for (int i = 0; i < 8; i++) cyc(1, 0, 1, 1, 0, 16'h0);

      // LIFO push+pop and pass-through
      cyc(1, 1, 0, 0, 0, 16'd5);
      cyc(1, 1, 0, 0, 0, 16'd6);
      cyc(1, 1, 1, 0, 0, 16'd7);
      cyc(1, 0, 1, 0, 0, 16'h0);
      cyc(1, 0, 1, 0, 0, 16'h0);
      cyc(1, 1, 1, 0, 0, 16'd42);

      // mode change while non-empty is ignored until drained
      cyc(1, 1, 0, 0, 0, 16'd31);
      cyc(1, 1, 0, 1, 0, 16'd32);
      cyc(1, 1, 0, 1, 0, 16'd33);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0, 16'h0);
      cyc(1, 1, 0, 1, 0, 16'd34);
      cyc(1, 1, 0, 1, 0, 16'd35);
      cyc(0, 1, 1, 1, 0, 16'd99);
      cyc(0, 1, 0, 1, 0, 16'd98);
      for (int i = 0; i < 2; i++) cyc(1, 0, 1, 1, 0, 16'h0);

      // reset in mid-sequence at counter=5 with a flag raised
      for (int i = 1; i <= 9; i++) cyc(1, 1, 0, 0, 0, 16'(100 + i));
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 16'h0);
      do_reset();

      // randomized traffic on the default instance
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 99) < 55,
             $urandom_range(0, 99) < 45, $urandom_range(0, 5) == 0 ? ~mode : mode,
             $urandom_range(0, 15) == 0, 16'($urandom));
      idle_cyc();

      // 16-bit, depth-5 instance
      sel = 1'b1;
      do_reset();
      for (int i = 1; i <= 6; i++) cyc(1, 1, 0, 1, 0, 16'(16'hA000 + i));
      for (int i = 0; i < 6; i++) cyc(1, 0, 1, 1, 0, 16'h0);
      for (int i = 1; i <= 6; i++) cyc(1, 1, 0, 0, 0, 16'(16'hB000 + i));
      cyc(1, 1, 1, 0, 0, 16'hBEEF);
      for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 0, 16'h0);
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 99) < 55,
             $urandom_range(0, 99) < 45, $urandom_range(0, 5) == 0 ? ~mode : mode,
             $urandom_range(0, 15) == 0, 16'($urandom));

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
